apb_system: RTL and testbench

APB_SYSTEM -- requirements
Module: apb_system

---
 rtl/apb_pkg.sv | 6 +
 rtl/apb_slave.sv | 30 +++
 rtl/apb_system.sv | 59 +++++
 tb/tb_apb_system.sv | 124 ++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and width defaults for the APB master/slave pair
package apb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
endpackage

// File: rtl/apb_slave.sv
// apb_slave: zero-wait-state register memory with registered read data, cleared on reset
module apb_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  assign pready = 1'b1;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      prdata <= '0;
    end else if (psel && penable && pready) begin
      if (pwrite) mem[paddr] <= pwdata;
      else prdata <= mem[paddr];
    end
  end
endmodule

// File: rtl/apb_system.sv
// apb_system: APB master FSM driving an internal register-memory slave
module apb_system
  import apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PTX,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] PRDATA
);
  state_t state, next_state;
  logic psel, penable, pwrite, pready;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = PTX ? SETUP : IDLE;
      SETUP:   next_state = ACCESS;
      ACCESS:  next_state = pready ? (PTX ? SETUP : IDLE) : ACCESS;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    psel    = state != IDLE;
    penable = state == ACCESS;
  end
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (next_state == SETUP) begin
      pwrite <= WRITE;
      paddr  <= ADDR;
      pwdata <= WDATA;
    end
  end
  apb_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slave (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (PRDATA),
    .pready  (pready)
  );
endmodule

// File: tb/tb_apb_system.sv
// tb_apb_system: directed table-driven check of the APB master/slave pair
module tb_apb_system;
  import apb_pkg::*;
  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PTX = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDR = '0;
  logic [31:0] WDATA = '0;
  logic [31:0] PRDATA;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic        ptx;
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        sel;
    logic        en;
  } vec_t;
  vec_t vt [23];
  apb_system #(.ADDR_W(8), .DATA_W(32)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PTX    (PTX),
    .WRITE  (WRITE),
    .ADDR   (ADDR),
    .WDATA  (WDATA),
    .PRDATA (PRDATA)
  );
  always #5 PCLK = ~PCLK;
  function automatic vec_t mk(logic p, logic w, logic [7:0] a, logic [31:0] d, logic [31:0] rd, logic s, logic e);
    vec_t v;
    v.ptx = p; v.wr = w; v.a = a; v.d = d; v.rd = rd; v.sel = s; v.en = e;
    return v;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(logic p, logic w, logic [7:0] a, logic [31:0] d);
    @(negedge PCLK);
    PTX = p; WRITE = w; ADDR = a; WDATA = d;
    @(posedge PCLK);
    #1;
  endtask
  initial begin
    // write A5, then back-to-back read of A5
    vt[0]  = mk(1'b1, 1'b1, 8'hA5, 32'hABCDABCD, 32'h0, 1'b1, 1'b0);
    vt[1]  = mk(1'b1, 1'b1, 8'hA5, 32'hABCDABCD, 32'h0, 1'b1, 1'b1);
    vt[2]  = mk(1'b1, 1'b0, 8'hA5, 32'h0,        32'h0, 1'b1, 1'b0);
    vt[3]  = mk(1'b1, 1'b0, 8'hA5, 32'h0,        32'h0, 1'b1, 1'b1);
    vt[4]  = mk(1'b0, 1'b0, 8'hA5, 32'h0,        32'hABCDABCD, 1'b0, 1'b0);
    vt[5]  = mk(1'b0, 1'b0, 8'h00, 32'h0,        32'hABCDABCD, 1'b0, 1'b0);
    // back-to-back write 10 then read 10
    vt[6]  = mk(1'b1, 1'b1, 8'h10, 32'h11112222, 32'hABCDABCD, 1'b1, 1'b0);
    vt[7]  = mk(1'b1, 1'b1, 8'h10, 32'h11112222, 32'hABCDABCD, 1'b1, 1'b1);
    vt[8]  = mk(1'b1, 1'b0, 8'h10, 32'h0,        32'hABCDABCD, 1'b1, 1'b0);
    vt[9]  = mk(1'b1, 1'b0, 8'h10, 32'h0,        32'hABCDABCD, 1'b1, 1'b1);
    vt[10] = mk(1'b0, 1'b0, 8'h10, 32'h0,        32'h11112222, 1'b0, 1'b0);
    // write 3C while inputs wander and PTX drops mid-transfer
    vt[11] = mk(1'b1, 1'b1, 8'h3C, 32'hDEADBEEF, 32'h11112222, 1'b1, 1'b0);
    vt[12] = mk(1'b0, 1'b0, 8'h00, 32'h12345678, 32'h11112222, 1'b1, 1'b1);
    vt[13] = mk(1'b0, 1'b1, 8'h00, 32'h12345678, 32'h11112222, 1'b0, 1'b0);
    // read 3C, then 00 (must be untouched), then FF (top address)
    vt[14] = mk(1'b1, 1'b0, 8'h3C, 32'h0,        32'h11112222, 1'b1, 1'b0);
    vt[15] = mk(1'b0, 1'b1, 8'h00, 32'h0,        32'h11112222, 1'b1, 1'b1);
    vt[16] = mk(1'b0, 1'b0, 8'h00, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    vt[17] = mk(1'b1, 1'b0, 8'h00, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
    vt[18] = mk(1'b0, 1'b0, 8'h00, 32'h0,        32'hDEADBEEF, 1'b1, 1'b1);
    vt[19] = mk(1'b1, 1'b0, 8'hFF, 32'h0,        32'h0,        1'b1, 1'b0);
    vt[20] = mk(1'b0, 1'b0, 8'hFF, 32'h0,        32'h0,        1'b1, 1'b1);
    // read 10 again so PRDATA is nonzero before the reset test
    vt[21] = mk(1'b1, 1'b0, 8'h10, 32'h0,        32'h0,        1'b1, 1'b0);
    vt[22] = mk(1'b0, 1'b0, 8'h10, 32'h0,        32'h0,        1'b1, 1'b1);
    repeat (2) @(posedge PCLK);
    #1;
    check("reset_prdata", PRDATA, 32'h0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    check("reset_psel", 32'(dut.psel), 32'h0);
    check("reset_penable", 32'(dut.penable), 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int i = 0; i < 23; i++) begin
      cyc(vt[i].ptx, vt[i].wr, vt[i].a, vt[i].d);
      check($sformatf("v%0d_prdata", i), PRDATA, vt[i].rd);
      check($sformatf("v%0d_psel", i), 32'(dut.psel), 32'(vt[i].sel));
      check($sformatf("v%0d_penable", i), 32'(dut.penable), 32'(vt[i].en));
    end
    cyc(1'b0, 1'b0, 8'h00, 32'h0);
    check("pre_reset_prdata", PRDATA, 32'h11112222);
    cyc(1'b1, 1'b1, 8'h20, 32'h55AA55AA);
    cyc(1'b0, 1'b1, 8'h20, 32'h55AA55AA);
    check("mid_access_penable", 32'(dut.penable), 32'h1);
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    check("async_rst_prdata", PRDATA, 32'h0);
    check("async_rst_state", 32'(dut.state), 32'(IDLE));
    check("async_rst_psel", 32'(dut.psel), 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    cyc(1'b1, 1'b0, 8'h20, 32'h0);
    check("post_rst_first_setup", 32'(dut.state), 32'(SETUP));
    cyc(1'b1, 1'b0, 8'h20, 32'h0);
    cyc(1'b1, 1'b0, 8'h10, 32'h0);
    check("rd20_after_rst", PRDATA, 32'h0);
    cyc(1'b1, 1'b0, 8'h10, 32'h0);
    cyc(1'b1, 1'b1, 8'h20, 32'hCAFEF00D);
    check("rd10_cleared", PRDATA, 32'h0);
    cyc(1'b1, 1'b1, 8'h20, 32'hCAFEF00D);
    cyc(1'b1, 1'b0, 8'h20, 32'h0);
    cyc(1'b0, 1'b0, 8'h20, 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 32'h0);
    check("rd20_rewritten", PRDATA, 32'hCAFEF00D);
    check("final_idle", 32'(dut.state), 32'(IDLE));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
